// File: rtl/karatsuba_pkg.sv
// Shared constants and FSM encoding for the sequential Karatsuba GF(2)[x] multiplier.
package karatsuba_pkg;

  localparam int unsigned N = 233;
  localparam int unsigned L = 116;
  localparam int unsigned H = N - L;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_HH  = 3'd1,
    MUL_LL  = 3'd2,
    MUL_MM  = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/clmul_serial.sv
// Bit-serial W x W carry-less multiplier, MSB-first Horner scheme, one multiplier bit per cycle.
module clmul_serial #(
  parameter int unsigned W = 117
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    y,
  output logic [2*W-2:0]  prod_c
);

  localparam int unsigned AW   = 2*W - 1;
  localparam int unsigned ACCW = AW - 1;

  logic [W-1:0]    x_r;
  logic [W-1:0]    y_r;
  logic [ACCW-1:0] acc;

  // Accumulator value after the current step; after the final step this is the full product.
  assign prod_c = {acc, 1'b0} ^ (y_r[W-1] ? AW'(x_r) : '0);

  // Load consumes the multiplier MSB in the same cycle, so W cycles cover all W bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r <= '0;
      y_r <= '0;
      acc <= '0;
    end else if (load) begin
      x_r <= x;
      y_r <= {y[W-2:0], 1'b0};
      acc <= y[W-1] ? ACCW'(x) : '0;
    end else if (step) begin
      y_r <= {y_r[W-2:0], 1'b0};
      acc <= prod_c[ACCW-1:0];
    end
  end

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential one-level Karatsuba carry-less multiplier: three half-width products on one
// shared serial multiplier, then an XOR-only recombination.
module karatsuba_seq_ctrl #(
  parameter int unsigned N = karatsuba_pkg::N,
  parameter int unsigned L = karatsuba_pkg::L
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] c
);

  import karatsuba_pkg::*;

  localparam int unsigned HW = N - L;
  localparam int unsigned PW = 2*HW - 1;
  localparam int unsigned CW = 2*N;
  localparam int unsigned BW = $clog2(HW);

  state_e          state;
  state_e          state_nxt;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [BW-1:0]   cnt;
  logic [PW-1:0]   p_hh;
  logic [PW-1:0]   p_ll;
  logic [PW-1:0]   p_mm;
  logic            in_mul_c;
  logic            last_bit_c;
  logic            mul_load_c;
  logic            mul_step_c;
  logic [HW-1:0]   a_hi_c;
  logic [HW-1:0]   a_lo_c;
  logic [HW-1:0]   b_hi_c;
  logic [HW-1:0]   b_lo_c;
  logic [HW-1:0]   mul_x_c;
  logic [HW-1:0]   mul_y_c;
  logic [PW-1:0]   mul_prod_c;
  logic [CW-1:0]   c_nxt_c;

  assign a_hi_c = a_r[N-1:L];
  assign b_hi_c = b_r[N-1:L];
  assign a_lo_c = HW'(a_r[L-1:0]);
  assign b_lo_c = HW'(b_r[L-1:0]);

  assign c_nxt_c = (CW'(p_hh) << (2*L)) ^ (CW'(p_hh ^ p_ll ^ p_mm) << L) ^ CW'(p_ll);

  // Multiplier control and operand select for the active partial product.
  always_comb begin
    in_mul_c   = (state == MUL_HH) || (state == MUL_LL) || (state == MUL_MM);
    last_bit_c = in_mul_c && (cnt == BW'(HW-1));
    mul_load_c = in_mul_c && (cnt == '0);
    mul_step_c = in_mul_c && (cnt != '0);
    mul_x_c    = a_hi_c;
    mul_y_c    = b_hi_c;
    case (state)
      MUL_LL: begin
        mul_x_c = a_lo_c;
        mul_y_c = b_lo_c;
      end
      MUL_MM: begin
        mul_x_c = a_hi_c ^ a_lo_c;
        mul_y_c = b_hi_c ^ b_lo_c;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL_HH;
      MUL_HH:  if (last_bit_c) state_nxt = MUL_LL;
      MUL_LL:  if (last_bit_c) state_nxt = MUL_MM;
      MUL_MM:  if (last_bit_c) state_nxt = COMBINE;
      COMBINE: state_nxt = DONE;
      DONE:    if (out_ready && out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Datapath and registered outputs; partial products are taken on each MUL state's last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      p_hh      <= '0;
      p_ll      <= '0;
      p_mm      <= '0;
      c         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        a_r <= a;
        b_r <= b;
      end
      cnt <= (in_mul_c && (state_nxt == state)) ? cnt + BW'(1) : '0;
      if (last_bit_c) begin
        case (state)
          MUL_HH:  p_hh <= mul_prod_c;
          MUL_LL:  p_ll <= mul_prod_c;
          default: p_mm <= mul_prod_c;
        endcase
      end
      if ((state == COMBINE) && !abort) c <= c_nxt_c;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state == DONE) && (state_nxt == DONE);
    end
  end

  clmul_serial #(.W(HW)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load_c),
    .step   (mul_step_c),
    .x      (mul_x_c),
    .y      (mul_y_c),
    .prod_c (mul_prod_c)
  );

endmodule
